// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic light controller and its lamp monitor:
// light codes, the illegal code, monitor fault codes and monitor states.
package tlc_pkg;

   localparam logic [1:0] LIGHT_RED = 2'b00;
   localparam logic [1:0] LIGHT_YEL = 2'b01;
   localparam logic [1:0] LIGHT_GRN = 2'b11;
   localparam logic [1:0] LIGHT_BAD = 2'b10;

   localparam logic [2:0] FC_NONE      = 3'b000;
   localparam logic [2:0] FC_ILLEGAL   = 3'b001;
   localparam logic [2:0] FC_CONFLICT  = 3'b010;
   localparam logic [2:0] FC_TRANS_A   = 3'b011;
   localparam logic [2:0] FC_TRANS_B   = 3'b100;
   localparam logic [2:0] FC_SHORT_YEL = 3'b101;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_FAIL = 1'b1
   } mon_state_t;

   // R->Y, G->R and Y->G are the only forbidden colour steps; a step that
   // touches the illegal code is reported as an illegal code instead.
   function automatic logic step_illegal(input logic [1:0] prev, input logic [1:0] cur);
      logic bad;
      bad = 1'b0;
      if (prev != LIGHT_BAD && cur != LIGHT_BAD) begin
         bad = (prev == LIGHT_RED && cur == LIGHT_YEL) ||
               (prev == LIGHT_GRN && cur == LIGHT_RED) ||
               (prev == LIGHT_YEL && cur == LIGHT_GRN);
      end
      return bad;
   endfunction

endpackage

// File: rtl/tlc_approach_check.sv
// Per-approach sample pipeline, rule checks and one-hot lamp decode.
// Build option: TLC_MON_YEL_CHECK_EN adds the yellow-run counter and the
// short-yellow flag; without it Y->R is always accepted.
module tlc_approach_check
   import tlc_pkg::*;
#(
   parameter int MIN_YEL = 4
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] code,
   input  logic       clr_yel,
   output logic [1:0] s_cur,
   output logic       bad_code,
   output logic       bad_step,
   output logic       short_yel,
   output logic       lamp_red,
   output logic       lamp_yel,
   output logic       lamp_grn
);

   logic [1:0] s_q;
   logic [1:0] p_q;

   // current and previous samples of the light code, updated every cycle
   always_ff @(posedge CLK) begin
      if (!RST) begin
         s_q <= LIGHT_RED;
         p_q <= LIGHT_RED;
      end else begin
         s_q <= code;
         p_q <= s_q;
      end
   end

   assign s_cur    = s_q;
   assign bad_code = (s_q == LIGHT_BAD);
   assign bad_step = step_illegal(p_q, s_q);

`ifdef TLC_MON_YEL_CHECK_EN
   localparam int            YW    = $clog2(MIN_YEL + 1);
   localparam logic [YW-1:0] Y_SAT = YW'(MIN_YEL);

   logic [YW-1:0] y_q;

   // yellow run length, one sample behind S so it still holds the finished run at Y->R
   always_ff @(posedge CLK) begin
      if (!RST || clr_yel) begin
         y_q <= '0;
      end else if (s_q != LIGHT_YEL) begin
         y_q <= '0;
      end else if (p_q != LIGHT_YEL) begin
         y_q <= YW'(1);
      end else if (y_q != Y_SAT) begin
         y_q <= y_q + 1'b1;
      end
   end

   assign short_yel = (p_q == LIGHT_YEL) && (s_q == LIGHT_RED) && (y_q < Y_SAT);
`else
   logic unused_cfg;
   assign unused_cfg = clr_yel ^ (MIN_YEL > 0);
   assign short_yel  = 1'b0;
`endif

   // one-hot lamp decode of the current sample; the illegal code lights nothing
   always_comb begin
      lamp_red = 1'b0;
      lamp_yel = 1'b0;
      lamp_grn = 1'b0;
      case (s_q)
         LIGHT_RED: lamp_red = 1'b1;
         LIGHT_YEL: lamp_yel = 1'b1;
         LIGHT_GRN: lamp_grn = 1'b1;
         default:   ;
      endcase
   end

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp-side decoder and safety monitor for the two approach light codes.
// Any violation forces flashing red until an operator clear with both
// approaches red. Build option: TLC_MON_YEL_CHECK_EN (short-yellow check).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | lamps follow the sampled codes; violations mask to all-red
// ST_FAIL | first fault latched; both reds flash with FLASH_DIV half-period
module tlc_lamp_monitor
   import tlc_pkg::*;
#(
   parameter int MIN_YEL   = 4,
   parameter int FLASH_DIV = 8
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] LA,
   input  logic [1:0] LB,
   input  logic       CLR_FAULT,
   output logic       A_RED,
   output logic       A_YEL,
   output logic       A_GRN,
   output logic       B_RED,
   output logic       B_YEL,
   output logic       B_GRN,
   output logic       FAULT,
   output logic [2:0] FAULT_CODE,
   output logic       FLASH
);

   localparam int            CW       = $clog2(FLASH_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_DIV - 1);

   mon_state_t    state_q, state_d;
   logic [2:0]    code_q, code_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   logic [1:0] s_a, s_b;
   logic       a_bad_code, a_bad_step, a_short, a_red, a_yel, a_grn;
   logic       b_bad_code, b_bad_step, b_short, b_red, b_yel, b_grn;
   logic       conflict;
   logic       clear_ok;
   logic [2:0] fault_now;

   tlc_approach_check #(.MIN_YEL(MIN_YEL)) u_chk_a (
      .CLK       (CLK),
      .RST       (RST),
      .code      (LA),
      .clr_yel   (clear_ok),
      .s_cur     (s_a),
      .bad_code  (a_bad_code),
      .bad_step  (a_bad_step),
      .short_yel (a_short),
      .lamp_red  (a_red),
      .lamp_yel  (a_yel),
      .lamp_grn  (a_grn)
   );

   tlc_approach_check #(.MIN_YEL(MIN_YEL)) u_chk_b (
      .CLK       (CLK),
      .RST       (RST),
      .code      (LB),
      .clr_yel   (clear_ok),
      .s_cur     (s_b),
      .bad_code  (b_bad_code),
      .bad_step  (b_bad_step),
      .short_yel (b_short),
      .lamp_red  (b_red),
      .lamp_yel  (b_yel),
      .lamp_grn  (b_grn)
   );

   assign conflict = (s_a != LIGHT_RED) && (s_b != LIGHT_RED);
   assign clear_ok = (state_q == ST_FAIL) && CLR_FAULT &&
                     (s_a == LIGHT_RED) && (s_b == LIGHT_RED);

   // highest-priority violation present on the current samples
   always_comb begin
      fault_now = FC_NONE;
      if (conflict) begin
         fault_now = FC_CONFLICT;
      end else if (a_bad_code || b_bad_code) begin
         fault_now = FC_ILLEGAL;
      end else if (a_bad_step) begin
         fault_now = FC_TRANS_A;
      end else if (b_bad_step) begin
         fault_now = FC_TRANS_B;
      end else if (a_short || b_short) begin
         fault_now = FC_SHORT_YEL;
      end
   end

   // state register, fault latch and flash sequencer
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_RUN;
         code_q  <= FC_NONE;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // next state, fault capture, flash timing and lamp outputs
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      A_RED   = 1'b1;
      A_YEL   = 1'b0;
      A_GRN   = 1'b0;
      B_RED   = 1'b1;
      B_YEL   = 1'b0;
      B_GRN   = 1'b0;
      FAULT   = 1'b0;
      FLASH   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (fault_now != FC_NONE) begin
               state_d = ST_FAIL;
               code_d  = fault_now;
               cnt_d   = '0;
               phase_d = 1'b1;
            end else begin
               A_RED = a_red;
               A_YEL = a_yel;
               A_GRN = a_grn;
               B_RED = b_red;
               B_YEL = b_yel;
               B_GRN = b_grn;
            end
         end
         ST_FAIL: begin
            A_RED = phase_q;
            B_RED = phase_q;
            FAULT = 1'b1;
            FLASH = 1'b1;
            if (clear_ok) begin
               state_d = ST_RUN;
               code_d  = FC_NONE;
               cnt_d   = '0;
               phase_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign FAULT_CODE = code_q;

endmodule

// File: doc/tlc_lamp_monitor.md
# tlc_lamp_monitor

Lamp-side decoder and safety monitor for the traffic light controller's light-code outputs. Samples the two 2-bit approach codes (LA, LB), decodes them into six individual lamp drives, and checks every sample for illegal codes, conflicting greens, illegal colour transitions and short yellows. On any violation it latches a fault code and forces both approaches into flashing red until an operator clear. It sits between the controller and the lamp drivers.

## Interface
- MIN_YEL, 4: minimum consecutive Yellow samples per approach before Red is accepted; legal range 1..255.
- FLASH_DIV, 8: fail-safe flash half-period in CLK cycles; legal range 2..65535.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-low.
- LA  input  2  approach A light code: Red=00, Yellow=01, Green=11; 10 is illegal.
- LB  input  2  approach B light code, same encoding as LA.
- CLR_FAULT  input  1  level; requests exit from fail-safe.
- A_RED, A_YEL, A_GRN  output  1 each  approach A lamp drives.
- B_RED, B_YEL, B_GRN  output  1 each  approach B lamp drives.
- FAULT  output  1  high while in FAIL.
- FAULT_CODE  output  3  latched first-fault cause; 000 when no fault.
- FLASH  output  1  high while the flash sequencer is active.

## Operation
- Per-approach registers:
  - S_x holds the current sample of Lx; it samples every cycle in both states.
  - P_x holds the previous sample, i.e. the old S_x.
  - Y_x counts consecutive Yellow samples, saturating at MIN_YEL, with width clog2(MIN_YEL+1).
- Y_x update rule:
  - S_x is not Yellow: Y_x is 0.
  - S_x becomes Yellow: Y_x loads 1.
  - S_x remains Yellow: Y_x increments until it saturates.
- Checks are combinational on S/P/Y and are evaluated only in RUN.
- Fault codes, highest priority first:
  - 010 conflict: S_A is not Red and S_B is not Red.
  - 001 illegal code: S_A or S_B equals 10.
  - 011 illegal A transition: P_A to S_A is R→Y, G→R or Y→G.
  - 100 illegal B transition: same rule applied to approach B.
  - 101 short yellow: P_x is Y, S_x is R, and Y_x < MIN_YEL at the prior sample.
- Legal per-approach transitions: R→R, R→G, G→G, G→Y, Y→Y, Y→R.
- Transitions whose previous or current sample is code 10 are not also reported as illegal transitions.
- States: RUN and FAIL.
- RUN behaviour:
  - With no violation, lamps decode S_A and S_B one-hot.
  - On a violation, lamps are masked to A_RED=B_RED=1 with all other lamps 0 in the same cycle.
  - On the next edge the state goes to FAIL, FAULT_CODE latches the highest-priority active code, the flash counter is cleared and the flash phase is set to 1.
- FAIL behaviour:
  - The flash counter counts 0..FLASH_DIV-1; the phase toggles when the counter wraps.
  - A_RED=B_RED=phase; all other lamps 0; FAULT=1; FLASH=1.
  - Further violations are ignored; the first fault code is held.
- Exit from FAIL:
  - Condition: CLR_FAULT=1 and S_A=S_B=Red at an edge.
  - Effect: next state RUN, FAULT_CODE=000, Y_A=Y_B=0, flash counter and phase cleared.
  - CLR_FAULT with either approach not Red is ignored.
  - CLR_FAULT in RUN has no effect.
- Reset (RST=0 at an edge, including mid-FAIL or mid-flash):
  - State RUN; S and P are Red; Y, flash counter and phase are 0.
  - Output values: A_RED=B_RED=1, all other lamps 0, FAULT=0, FAULT_CODE=000, FLASH=0.

## Timing
- Input-to-lamp latency: 1 cycle. A code applied before edge n appears on the lamps after edge n.
- A bad code is never shown on the lamps; it is masked in the same cycle it reaches S.
- FAULT asserts 1 cycle after the bad sample reaches S, i.e. 2 edges after the input is applied.
- FAIL entry:
  - The red-on phase holds for FLASH_DIV cycles after entry.
  - Then red-off for FLASH_DIV cycles, repeating.
- Clear latency: the exit condition sampled at edge n puts normal decoded lamps out after edge n.

## Configuration
- TLC_MON_YEL_CHECK_EN defined:
  - The Y_x counters and fault 101 exist.
  - MIN_YEL is honoured.
- TLC_MON_YEL_CHECK_EN undefined:
  - No counters are built.
  - MIN_YEL is ignored.
  - Y→R is always legal.
  - Code 101 is never produced.
  - All other behaviour is identical.

## Structure
- The shared package tlc_pkg holds:
  - The light encodings Red, Yellow and Green, shared with the controller.
  - The illegal code 10.
  - The five fault-code constants.
  - The RUN/FAIL state encoding.
- Sub-module tlc_approach_check, instantiated once per approach:
  - Holds the S/P/Y registers.
  - Flags illegal code, illegal transition and short yellow.
  - Provides the one-hot lamp decode.
- The top level holds conflict detection, priority encoding, the state register, the fault latch and the flash sequencer.

## Test plan
- Legal cycle, MIN_YEL=4. Stimulus: LA=G for 10 cycles, Y for 4, R; then LB=G, Y×4, R. Response: lamps track with 1-cycle latency; FAULT stays 0.
- Conflict. Stimulus: LA=G, LB=11 in the same cycle. Response: lamps show both red that cycle; FAULT=1 next cycle; FAULT_CODE=010.
- Priority. Stimulus: LA=10 together with LB=G. Response: FAULT_CODE=010. Repeat with LA=10, LB=R. Response: FAULT_CODE=001.
- Short yellow, MIN_YEL=4. Stimulus: LA G→Y×3→R. Response: FAULT_CODE=101. With TLC_MON_YEL_CHECK_EN undefined, the same stimulus gives no fault.
- Flash and clear, FLASH_DIV=8. Stimulus: illegal LB R→Y.
  - Response: FAULT_CODE=100; A_RED toggles every 8 cycles.
  - CLR_FAULT with LB=Y is ignored.
  - CLR_FAULT with LA=LB=R returns to RUN; FAULT_CODE becomes 000.
- Reset mid-FAIL. Stimulus: RST=0 for 1 edge during the red-off phase. Response: A_RED=B_RED=1, FAULT=0, FAULT_CODE=000, FLASH=0 after that edge.
